// File: rtl/hazard_forward_unit.sv
// rtl/hazard_forward_unit.sv - EX-stage operand forwarding selects and load-use stall detection
//
// Purpose:
//   Keeps a shadow copy of the register tags for the instructions in EX, MEM
//   and WB. From those flops it derives the ALU operand mux selects for EX
//   and flags load-use hazards against the instruction currently in ID.
//   Select encoding: 00 = ID/EX value, 01 = MEM/WB result, 10 = EX/MEM result.
//
// Ports:
//   clk, rst_n           clock (rising edge), asynchronous active-low reset
//   id_rs, id_rt         source indices of the ID instruction
//   id_uses_rs/rt        ID instruction actually reads that source
//   id_rd                destination index of the ID instruction (after RegDst)
//   id_reg_write         ID instruction writes the register file
//   id_mem_read          ID instruction is a load
//   ex_flush             taken branch/jump resolved in EX; kills ID and IF
//   fwd_a_sel/fwd_b_sel  operand A/B mux selects for the EX instruction
//   stall                load-use stall request (combinational)
//   stall_count          saturating count of stall cycles
module hazard_forward_unit #(
  parameter int REG_W = 5,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [REG_W-1:0] id_rs,
  input  logic [REG_W-1:0] id_rt,
  input  logic             id_uses_rs,
  input  logic             id_uses_rt,
  input  logic [REG_W-1:0] id_rd,
  input  logic             id_reg_write,
  input  logic             id_mem_read,
  input  logic             ex_flush,
  output logic [1:0]       fwd_a_sel,
  output logic [1:0]       fwd_b_sel,
  output logic             stall,
  output logic [CNT_W-1:0] stall_count
);

  // EX shadow slot
  logic             ex_valid;
  logic [REG_W-1:0] ex_rs;
  logic [REG_W-1:0] ex_rt;
  logic             ex_uses_rs;
  logic             ex_uses_rt;
  logic [REG_W-1:0] ex_rd;
  logic             ex_reg_write;
  logic             ex_mem_read;

  // MEM and WB shadow slots. The load flag is only consulted while the load
  // sits in EX, so it is not carried further down the shadow pipeline.
  logic [REG_W-1:0] mem_rd;
  logic             mem_reg_write;
  logic [REG_W-1:0] wb_rd;
  logic             wb_reg_write;

  logic             bubble;

  // A bubble carries valid = 0 and reg_write = 0, so it neither consumes
  // nor produces anything downstream.
  assign bubble = stall | ex_flush;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ex_valid      <= 1'b0;
      ex_rs         <= '0;
      ex_rt         <= '0;
      ex_uses_rs    <= 1'b0;
      ex_uses_rt    <= 1'b0;
      ex_rd         <= '0;
      ex_reg_write  <= 1'b0;
      ex_mem_read   <= 1'b0;
      mem_rd        <= '0;
      mem_reg_write <= 1'b0;
      wb_rd         <= '0;
      wb_reg_write  <= 1'b0;
    end else begin
      wb_rd         <= mem_rd;
      wb_reg_write  <= mem_reg_write;
      mem_rd        <= ex_rd;
      mem_reg_write <= ex_reg_write;
      if (bubble) begin
        ex_valid     <= 1'b0;
        ex_rs        <= '0;
        ex_rt        <= '0;
        ex_uses_rs   <= 1'b0;
        ex_uses_rt   <= 1'b0;
        ex_rd        <= '0;
        ex_reg_write <= 1'b0;
        ex_mem_read  <= 1'b0;
      end else begin
        ex_valid     <= 1'b1;
        ex_rs        <= id_rs;
        ex_rt        <= id_rt;
        ex_uses_rs   <= id_uses_rs;
        ex_uses_rt   <= id_uses_rt;
        ex_rd        <= id_rd;
        ex_reg_write <= id_reg_write;
        ex_mem_read  <= id_mem_read;
      end
    end
  end

  // Producer matches; r0 is hardwired zero so it is never a producer.
  logic mem_prod;
  logic wb_prod;
  logic a_mem_hit;
  logic a_wb_hit;
  logic b_mem_hit;
  logic b_wb_hit;

  assign mem_prod  = mem_reg_write & (mem_rd != '0);
  assign wb_prod   = wb_reg_write & (wb_rd != '0);
  assign a_mem_hit = ex_valid & ex_uses_rs & mem_prod & (mem_rd == ex_rs);
  assign a_wb_hit  = ex_valid & ex_uses_rs & wb_prod  & (wb_rd  == ex_rs);
  assign b_mem_hit = ex_valid & ex_uses_rt & mem_prod & (mem_rd == ex_rt);
  assign b_wb_hit  = ex_valid & ex_uses_rt & wb_prod  & (wb_rd  == ex_rt);

  // MEM holds the younger producer, so it outranks WB.
  assign fwd_a_sel = a_mem_hit ? 2'b10 : (a_wb_hit ? 2'b01 : 2'b00);
  assign fwd_b_sel = b_mem_hit ? 2'b10 : (b_wb_hit ? 2'b01 : 2'b00);

  // A flush kills the would-be consumer in ID, so no stall is needed for it.
  assign stall = ex_valid & ex_mem_read & (ex_rd != '0) & ~ex_flush &
                 ((id_uses_rs & (id_rs == ex_rd)) | (id_uses_rt & (id_rt == ex_rd)));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stall_count <= '0;
    end else if (stall && (stall_count != '1)) begin
      stall_count <= stall_count + CNT_W'(1);
    end
  end

endmodule

// File: tb/tb_hazard_forward_unit.sv
// tb/tb_hazard_forward_unit.sv - directed and random checks of hazard_forward_unit against a pipeline model
module tb_hazard_forward_unit;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [4:0]  id_rs, id_rt, id_rd;
  logic        id_uses_rs, id_uses_rt, id_reg_write, id_mem_read, ex_flush;
  logic [1:0]  fwd_a_sel, fwd_b_sel, fwd_a_sel2, fwd_b_sel2;
  logic        stall, stall2;
  logic [15:0] stall_count;
  logic [1:0]  stall_count2;

  int errors = 0;
  int checks = 0;

  hazard_forward_unit #(.REG_W(5), .CNT_W(16)) dut (
    .clk(clk), .rst_n(rst_n), .id_rs(id_rs), .id_rt(id_rt),
    .id_uses_rs(id_uses_rs), .id_uses_rt(id_uses_rt), .id_rd(id_rd),
    .id_reg_write(id_reg_write), .id_mem_read(id_mem_read), .ex_flush(ex_flush),
    .fwd_a_sel(fwd_a_sel), .fwd_b_sel(fwd_b_sel), .stall(stall),
    .stall_count(stall_count)
  );

  // Narrow counter instance so saturation is reachable in a short run.
  hazard_forward_unit #(.REG_W(5), .CNT_W(2)) dut2 (
    .clk(clk), .rst_n(rst_n), .id_rs(id_rs), .id_rt(id_rt),
    .id_uses_rs(id_uses_rs), .id_uses_rt(id_uses_rt), .id_rd(id_rd),
    .id_reg_write(id_reg_write), .id_mem_read(id_mem_read), .ex_flush(ex_flush),
    .fwd_a_sel(fwd_a_sel2), .fwd_b_sel(fwd_b_sel2), .stall(stall2),
    .stall_count(stall_count2)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    bit       v;
    bit [4:0] rs;
    bit [4:0] rt;
    bit       urs;
    bit       urt;
    bit [4:0] rd;
    bit       rw;
    bit       mr;
  } ins_t;

  // p[0] = EX, p[1] = MEM, p[2] = WB
  ins_t p [3];
  int   cnt;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Search older stages youngest-first for a register-file writer of src.
  function automatic logic [1:0] m_sel(input bit [4:0] src, input bit use_src);
    if (!p[0].v || !use_src) return 2'b00;
    for (int k = 1; k <= 2; k++)
      if (p[k].rw && p[k].rd != 0 && p[k].rd == src) return (k == 1) ? 2'b10 : 2'b01;
    return 2'b00;
  endfunction

  function automatic bit m_stall();
    if (!p[0].v || !p[0].mr || p[0].rd == 0 || ex_flush) return 1'b0;
    return (id_uses_rs && id_rs == p[0].rd) || (id_uses_rt && id_rt == p[0].rd);
  endfunction

  task automatic check_all();
    chk("fwd_a", 32'(fwd_a_sel), 32'(m_sel(p[0].rs, p[0].urs)));
    chk("fwd_b", 32'(fwd_b_sel), 32'(m_sel(p[0].rt, p[0].urt)));
    chk("stall", 32'(stall), 32'(m_stall()));
    chk("count", 32'(stall_count), (cnt > 65535) ? 32'd65535 : 32'(cnt));
    chk("count_sat2", 32'(stall_count2), (cnt > 3) ? 32'd3 : 32'(cnt));
  endtask

  task automatic drive(input bit [4:0] rs, input bit [4:0] rt, input bit urs, input bit urt,
                       input bit [4:0] rd, input bit rw, input bit mr, input bit fl);
    id_rs = rs; id_rt = rt; id_uses_rs = urs; id_uses_rt = urt;
    id_rd = rd; id_reg_write = rw; id_mem_read = mr; ex_flush = fl;
    #1;
    check_all();
  endtask

  task automatic nop();
    drive(0, 0, 0, 0, 0, 0, 0, 0);
  endtask

  task automatic tick();
    bit s;
    s = m_stall();
    if (s) cnt++;
    p[2] = p[1];
    p[1] = p[0];
    if (s || ex_flush) p[0] = '0;
    else p[0] = '{1'b1, id_rs, id_rt, id_uses_rs, id_uses_rt, id_rd, id_reg_write, id_mem_read};
    @(posedge clk);
    #1;
  endtask

  task automatic drain();
    for (int i = 0; i < 3; i++) begin nop(); tick(); end
  endtask

  bit [4:0] r_rs, r_rt, r_rd;
  bit       r_urs, r_urt, r_rw, r_mr, held;

  initial begin
    for (int k = 0; k < 3; k++) p[k] = '0;
    cnt = 0;
    rst_n = 1'b0;
    id_rs = 0; id_rt = 0; id_rd = 0;
    id_uses_rs = 0; id_uses_rt = 0; id_reg_write = 0; id_mem_read = 0; ex_flush = 0;
    #2;
    check_all();
    chk("reset_count", 32'(stall_count), 32'd0);
    rst_n = 1'b1;
    tick();
    drain();

    // 1: add r1 ; add r2, r1, r0
    drive(0, 0, 0, 0, 1, 1, 0, 0); tick();
    drive(1, 0, 1, 1, 2, 1, 0, 0); tick();
    nop();
    chk("t1_a", 32'(fwd_a_sel), 32'd2);
    chk("t1_b", 32'(fwd_b_sel), 32'd0);
    chk("t1_stall", 32'(stall), 32'd0);
    tick(); drain();

    // 2: add r1 ; unrelated ; sub r3, r2, r1
    drive(0, 0, 0, 0, 1, 1, 0, 0); tick();
    drive(7, 8, 1, 1, 9, 1, 0, 0); tick();
    drive(2, 1, 1, 1, 3, 1, 0, 0); tick();
    nop();
    chk("t2_a", 32'(fwd_a_sel), 32'd0);
    chk("t2_b", 32'(fwd_b_sel), 32'd1);
    tick(); drain();

    // 3: add r3 ; add r3 ; or r4, r3, r3
    drive(0, 0, 0, 0, 3, 1, 0, 0); tick();
    drive(0, 0, 0, 0, 3, 1, 0, 0); tick();
    drive(3, 3, 1, 1, 4, 1, 0, 0); tick();
    nop();
    chk("t3_a", 32'(fwd_a_sel), 32'd2);
    chk("t3_b", 32'(fwd_b_sel), 32'd2);
    tick(); drain();

    // 4: lw r4 ; add r5, r4, r4
    drive(0, 0, 0, 0, 4, 1, 1, 0); tick();
    drive(4, 4, 1, 1, 5, 1, 0, 0);
    chk("t4_stall1", 32'(stall), 32'd1);
    tick();
    drive(4, 4, 1, 1, 5, 1, 0, 0);
    chk("t4_stall2", 32'(stall), 32'd0);
    chk("t4_bubble_a", 32'(fwd_a_sel), 32'd0);
    tick();
    nop();
    chk("t4_a", 32'(fwd_a_sel), 32'd1);
    chk("t4_b", 32'(fwd_b_sel), 32'd1);
    chk("t4_count", 32'(stall_count), 32'd1);
    tick(); drain();

    // 5: writer of r0 never forwards; lw r0 never stalls
    drive(0, 0, 0, 0, 0, 1, 0, 0); tick();
    drive(0, 0, 1, 1, 6, 1, 0, 0); tick();
    nop();
    chk("t5_a", 32'(fwd_a_sel), 32'd0);
    chk("t5_b", 32'(fwd_b_sel), 32'd0);
    tick(); drain();
    drive(0, 0, 0, 0, 0, 1, 1, 0); tick();
    drive(0, 0, 1, 1, 6, 1, 0, 0);
    chk("t5_lw_r0", 32'(stall), 32'd0);
    tick(); drain();

    // 6: flush beats load-use; the killed consumer never reaches EX
    drive(0, 0, 0, 0, 6, 1, 1, 0); tick();
    drive(6, 0, 1, 0, 7, 1, 0, 1);
    chk("t6_stall", 32'(stall), 32'd0);
    tick();
    nop();
    chk("t6_bubble_a", 32'(fwd_a_sel), 32'd0);
    tick(); drain();

    // Reset asserted in the middle of a stall cycle
    drive(0, 0, 0, 0, 7, 1, 1, 0); tick();
    drive(7, 0, 1, 0, 8, 1, 0, 0);
    chk("rst_pre_stall", 32'(stall), 32'd1);
    #1 rst_n = 1'b0;
    #1;
    for (int k = 0; k < 3; k++) p[k] = '0;
    cnt = 0;
    chk("rst_stall", 32'(stall), 32'd0);
    chk("rst_a", 32'(fwd_a_sel), 32'd0);
    chk("rst_b", 32'(fwd_b_sel), 32'd0);
    chk("rst_count", 32'(stall_count), 32'd0);
    #1 rst_n = 1'b1;
    #1;
    check_all();
    tick(); drain();

    // Random traffic over a small register set to provoke many hazards
    held = 1'b0;
    for (int i = 0; i < 800; i++) begin
      if (!held) begin
        r_rs  = 5'($urandom_range(0, 3));
        r_rt  = 5'($urandom_range(0, 3));
        r_rd  = 5'($urandom_range(0, 3));
        r_urs = 1'($urandom);
        r_urt = 1'($urandom);
        r_rw  = ($urandom_range(0, 3) != 0);
        r_mr  = r_rw && ($urandom_range(0, 2) == 0);
      end
      drive(r_rs, r_rt, r_urs, r_urt, r_rd, r_rw, r_mr, ($urandom_range(0, 7) == 0));
      held = m_stall();
      tick();
    end
    nop();
    chk("final_sat2", 32'(stall_count2), (cnt > 3) ? 32'd3 : 32'(cnt));

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
